// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment clock display.
// Segment patterns are active-high {g,f,e,d,c,b,a}; digit indices map an[] bits.
package seven_seg_scan_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_N = 6;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned IDX_W = 3;

    typedef logic [BCD_W-1:0] bcd_t;

    // One full hh:mm:ss frame, most significant digit first
    typedef struct packed {
        bcd_t hh_t;
        bcd_t hh_u;
        bcd_t mm_t;
        bcd_t mm_u;
        bcd_t ss_t;
        bcd_t ss_u;
    } time_digits_t;

    localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

    localparam logic [IDX_W-1:0] DIG_SS_U = 3'd0;
    localparam logic [IDX_W-1:0] DIG_SS_T = 3'd1;
    localparam logic [IDX_W-1:0] DIG_MM_U = 3'd2;
    localparam logic [IDX_W-1:0] DIG_MM_T = 3'd3;
    localparam logic [IDX_W-1:0] DIG_HH_U = 3'd4;
    localparam logic [IDX_W-1:0] DIG_HH_T = 3'd5;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit/control inputs and driven display lines of the scan stage.
interface seven_seg_scan_if;
    import seven_seg_scan_pkg::*;

    logic             en;
    logic             blank_lz;
    logic             colon_tick;
    bcd_t             hh_t_in;
    bcd_t             hh_u_in;
    bcd_t             mm_t_in;
    bcd_t             mm_u_in;
    bcd_t             ss_t_in;
    bcd_t             ss_u_in;
    logic [SEG_W-1:0] seg;
    logic [DIG_N-1:0] an;
    logic             dp;

    modport master (
        output en, blank_lz, colon_tick,
        output hh_t_in, hh_u_in, mm_t_in, mm_u_in, ss_t_in, ss_u_in,
        input  seg, an, dp
    );

    modport slave (
        input  en, blank_lz, colon_tick,
        input  hh_t_in, hh_u_in, mm_t_in, mm_u_in, ss_t_in, ss_u_in,
        output seg, an, dp
    );

endinterface

// File: rtl/seven_seg_scan_bcd_to_7seg.sv
// BCD digit to active-high segment pattern; non-decimal codes render as a dash.
module bcd_to_7seg
    import seven_seg_scan_pkg::*;
(
    input  bcd_t             bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexes a snapshotted hh:mm:ss frame onto a 6-digit 7-segment bank
// with per-slot anti-ghost guard, leading-zero blanking and a toggling colon.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned GUARD      = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [DIG_N-1:0] AN_OFF  = ACTIVE_LOW ? {DIG_N{1'b1}} : {DIG_N{1'b0}};
    localparam logic             DP_OFF  = ACTIVE_LOW;

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic             en_q;
    logic             colon_on;
    time_digits_t     shadow;

    logic             scan_tick_c;
    logic             en_rise_c;
    logic             load_snap_c;
    time_digits_t     live_c;
    time_digits_t     src_c;
    bcd_t             digit_c;
    logic [SEG_W-1:0] seg_hi_c;
    logic             blank_c;
    logic             on_c;
    logic [SEG_W-1:0] seg_on_c;
    logic [DIG_N-1:0] an_on_c;
    logic             dp_on_c;

    assign live_c = '{hh_t: bus.hh_t_in, hh_u: bus.hh_u_in,
                      mm_t: bus.mm_t_in, mm_u: bus.mm_u_in,
                      ss_t: bus.ss_t_in, ss_u: bus.ss_u_in};

    assign scan_tick_c = bus.en && (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign en_rise_c   = bus.en && !en_q;
    assign load_snap_c = en_rise_c || (scan_tick_c && (idx == DIG_HH_T));

    // Prescaler and slot index, both parked at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= bus.en;
            if (!bus.en) begin
                div_cnt <= '0;
                idx     <= '0;
            end else if (scan_tick_c) begin
                div_cnt <= '0;
                idx     <= (idx == DIG_HH_T) ? DIG_SS_U : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            colon_on <= 1'b1;
        end else begin
            if (load_snap_c) begin
                shadow <= live_c;
            end
            if (bus.colon_tick) begin
                colon_on <= !colon_on;
            end
        end
    end

    // On the enable edge the shadow is still stale, so look through to the inputs
    always_comb begin
        src_c   = en_rise_c ? live_c : shadow;
        digit_c = '0;
        case (idx)
            DIG_SS_U: digit_c = src_c.ss_u;
            DIG_SS_T: digit_c = src_c.ss_t;
            DIG_MM_U: digit_c = src_c.mm_u;
            DIG_MM_T: digit_c = src_c.mm_t;
            DIG_HH_U: digit_c = src_c.hh_u;
            DIG_HH_T: digit_c = src_c.hh_t;
            default:  digit_c = '0;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd (digit_c),
        .seg (seg_hi_c)
    );

    always_comb begin
        blank_c  = (div_cnt < DIV_W'(GUARD)) ||
                   ((idx == DIG_HH_T) && bus.blank_lz && (src_c.hh_t == '0));
        on_c     = bus.en && !blank_c;
        seg_on_c = on_c ? seg_hi_c : '0;
        an_on_c  = on_c ? (DIG_N'(1) << idx) : '0;
        dp_on_c  = on_c && colon_on && ((idx == DIG_MM_U) || (idx == DIG_HH_U));
    end

    // Polarity is applied only here so the drive lines never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg <= SEG_OFF;
            bus.an  <= AN_OFF;
            bus.dp  <= DP_OFF;
        end else begin
            bus.seg <= seg_on_c ^ SEG_OFF;
            bus.an  <= an_on_c ^ AN_OFF;
            bus.dp  <= dp_on_c ^ DP_OFF;
        end
    end

endmodule
